retire_order: RTL and testbench

In-order retire sequencer at the writeback end of the dual-issue pipeline. It is the inverse of issue steering: it takes the two pipe results of each issued pair, uses the `first` tag carried down with the pair to restore program order, and drops the NOP bubbles that steering inserted. Surviving instructions go into an ordered FIFO that drains up to two per cycle to the commit/trace port, with upstream backpressure when space runs low.

---
 rtl/retire_order.sv | 105 ++++++++++
 tb/tb_retire_order.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/retire_order.sv
// In-order retire sequencer: restores program order of each dual-issue pair using the
// steering tag, drops NOP bubbles, and queues survivors in a FIFO drained up to two per cycle.
module retire_order #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter logic [INST_WIDTH-1:0] NOP_INSTRUCTION = INST_WIDTH'(32'h0000_0013)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    first,
  input  logic [INST_WIDTH-1:0]   inst0_in,
  input  logic [INST_WIDTH-1:0]   inst1_in,
  input  logic [DATA_WIDTH-1:0]   data0_in,
  input  logic [DATA_WIDTH-1:0]   data1_in,
  output logic                    out0_valid,
  output logic                    out1_valid,
  output logic [INST_WIDTH-1:0]   out0_inst,
  output logic [INST_WIDTH-1:0]   out1_inst,
  output logic [DATA_WIDTH-1:0]   out0_data,
  output logic [DATA_WIDTH-1:0]   out1_data,
  input  logic [1:0]              out_take,
  output logic [31:0]             retire_count,
  output logic                    overflow,
  output logic [$clog2(DEPTH):0]  debug_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [INST_WIDTH-1:0] inst_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];

  logic [PW-1:0] rd_ptr, wr_ptr, rd_ptr1, young_ptr;
  logic [PW:0]   count, count_next;

  logic [INST_WIDTH-1:0] older_inst, younger_inst;
  logic [DATA_WIDTH-1:0] older_data, younger_data;
  logic                  accept, wr_old, wr_young;
  logic [1:0]            n_writes, take_req, eff_take;

  // Handshake: a pair transfers on a rising edge where in_valid & in_ready; in_ready
  // depends only on registered occupancy, so upstream may hold or replay a refused pair.
  assign in_ready = (DEPTH_C - count) >= (PW+1)'(2);
  assign accept   = in_valid & in_ready;

  assign older_inst   = first ? inst1_in : inst0_in;
  assign older_data   = first ? data1_in : data0_in;
  assign younger_inst = first ? inst0_in : inst1_in;
  assign younger_data = first ? data0_in : data1_in;

  assign wr_old    = accept && (older_inst != NOP_INSTRUCTION);
  assign wr_young  = accept && (younger_inst != NOP_INSTRUCTION);
  assign n_writes  = {1'b0, wr_old} + {1'b0, wr_young};
  // A lone surviving younger entry collapses into wr_ptr.
  assign young_ptr = wr_ptr + PW'(wr_old);

  always_comb begin
    take_req = (out_take == 2'd3) ? 2'd2 : out_take;
    eff_take = take_req;
    if ((PW+1)'(take_req) > count) eff_take = count[1:0];
  end

  assign count_next = count + (PW+1)'(n_writes) - (PW+1)'(eff_take);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      retire_count <= '0;
      overflow     <= 1'b0;
    end else begin
      rd_ptr       <= rd_ptr + PW'(eff_take);
      wr_ptr       <= wr_ptr + PW'(n_writes);
      count        <= count_next;
      retire_count <= retire_count + 32'(eff_take);
      overflow     <= overflow | (in_valid & ~in_ready);
    end
  end

  // Storage carries no reset; validity is tracked entirely by count.
  always_ff @(posedge clk) begin
    if (wr_old) begin
      inst_mem[wr_ptr] <= older_inst;
      data_mem[wr_ptr] <= older_data;
    end
    if (wr_young) begin
      inst_mem[young_ptr] <= younger_inst;
      data_mem[young_ptr] <= younger_data;
    end
  end

  assign rd_ptr1     = rd_ptr + PW'(1);
  assign out0_valid  = count >= (PW+1)'(1);
  assign out1_valid  = count >= (PW+1)'(2);
  assign out0_inst   = out0_valid ? inst_mem[rd_ptr]  : NOP_INSTRUCTION;
  assign out1_inst   = out1_valid ? inst_mem[rd_ptr1] : NOP_INSTRUCTION;
  assign out0_data   = out0_valid ? data_mem[rd_ptr]  : '0;
  assign out1_data   = out1_valid ? data_mem[rd_ptr1] : '0;
  assign debug_count = count;

endmodule

// File: tb/tb_retire_order.sv
// Bench for retire_order: directed vector table, hand-written corner sequences, and
// random traffic checked against a queue-based model of the retire FIFO.
module tb_retire_order;

  localparam int DEPTH = 8;
  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] MASK = 32'hFFFF_0000;

  logic        clk;
  logic        reset;
  logic        in_valid, in_ready, first;
  logic [31:0] inst0_in, inst1_in, data0_in, data1_in;
  logic        out0_valid, out1_valid;
  logic [31:0] out0_inst, out1_inst, out0_data, out1_data;
  logic [1:0]  out_take;
  logic [31:0] retire_count;
  logic        overflow;
  logic [3:0]  debug_count;

  retire_order #(.DEPTH(DEPTH), .DATA_WIDTH(32), .INST_WIDTH(32), .NOP_INSTRUCTION(NOP)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .first(first),
    .inst0_in(inst0_in), .inst1_in(inst1_in), .data0_in(data0_in), .data1_in(data1_in),
    .out0_valid(out0_valid), .out1_valid(out1_valid), .out0_inst(out0_inst), .out1_inst(out1_inst),
    .out0_data(out0_data), .out1_data(out1_data), .out_take(out_take),
    .retire_count(retire_count), .overflow(overflow), .debug_count(debug_count)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model: program-ordered queue of surviving entries
  logic [31:0] exp_q[$];
  logic [31:0] exp_dq[$];
  logic [31:0] m_rc;
  logic        m_ovf;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    exp_dq.delete();
    m_rc  = '0;
    m_ovf = 1'b0;
  endtask

  task automatic model_step();
    int sz;
    int tk;
    logic [31:0] oi, od, yi, yd;
    sz = exp_q.size();
    tk = (out_take == 2'd3) ? 2 : int'(out_take);
    if (tk > sz) tk = sz;
    for (int k = 0; k < tk; k++) begin
      void'(exp_q.pop_front());
      void'(exp_dq.pop_front());
    end
    m_rc += 32'(tk);
    if (in_valid) begin
      if (DEPTH - sz >= 2) begin
        oi = first ? inst1_in : inst0_in;
        od = first ? data1_in : data0_in;
        yi = first ? inst0_in : inst1_in;
        yd = first ? data0_in : data1_in;
        if (oi != NOP) begin exp_q.push_back(oi); exp_dq.push_back(od); end
        if (yi != NOP) begin exp_q.push_back(yi); exp_dq.push_back(yd); end
      end else begin
        m_ovf = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    int sz;
    sz = exp_q.size();
    chk({tag, " in_ready"},   32'(in_ready),   32'((DEPTH - sz) >= 2));
    chk({tag, " out0_valid"}, 32'(out0_valid), 32'(sz >= 1));
    chk({tag, " out1_valid"}, 32'(out1_valid), 32'(sz >= 2));
    chk({tag, " out0_inst"},  out0_inst, (sz >= 1) ? exp_q[0]  : NOP);
    chk({tag, " out0_data"},  out0_data, (sz >= 1) ? exp_dq[0] : 32'h0);
    chk({tag, " out1_inst"},  out1_inst, (sz >= 2) ? exp_q[1]  : NOP);
    chk({tag, " out1_data"},  out1_data, (sz >= 2) ? exp_dq[1] : 32'h0);
    chk({tag, " retire_count"}, retire_count, m_rc);
    chk({tag, " overflow"},   32'(overflow), 32'(m_ovf));
    chk({tag, " count"},      32'(debug_count), 32'(sz));
  endtask

  // driver: present inputs, advance the model, clock, then check one step after the edge
  task automatic step_d(input logic v, input logic f, input logic [31:0] i0, input logic [31:0] i1,
                        input logic [31:0] d0, input logic [31:0] d1, input logic [1:0] tk,
                        input string tag);
    in_valid = v; first = f; inst0_in = i0; inst1_in = i1;
    data0_in = d0; data1_in = d1; out_take = tk;
    model_step();
    @(posedge clk); #1;
    check_model(tag);
  endtask

  task automatic step(input logic v, input logic f, input logic [31:0] i0, input logic [31:0] i1,
                      input logic [1:0] tk, input string tag);
    step_d(v, f, i0, i1, i0 ^ MASK, i1 ^ MASK, tk, tag);
  endtask

  task automatic do_reset();
    reset = 1'b0; in_valid = 1'b0; out_take = 2'd0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    model_reset();
    check_model("reset");
  endtask

  typedef struct {
    logic        v;
    logic        f;
    logic [31:0] i0;
    logic [31:0] i1;
    logic [1:0]  take;
    int          exp_cnt;
    logic [31:0] exp_o0;
    logic [31:0] exp_o1;
    logic [31:0] exp_rc;
  } vec_t;

  vec_t vecs[10];

  function automatic logic [31:0] I(input int n);
    return 32'h100 + 32'(n);
  endfunction

  function automatic logic [31:0] exp_data(input logic [31:0] inst);
    return (inst == NOP) ? 32'h0 : (inst ^ MASK);
  endfunction

  initial begin
    reset = 1'b0; in_valid = 1'b0; first = 1'b0; out_take = 2'd0;
    inst0_in = NOP; inst1_in = NOP; data0_in = '0; data1_in = '0;
    model_reset();

    // order restore, NOP drop, take clamp, take on empty
    vecs[0] = '{1'b1, 1'b0, I(1), I(2), 2'd0, 2, I(1), I(2), 0};
    vecs[1] = '{1'b1, 1'b1, I(4), I(3), 2'd0, 4, I(1), I(2), 0};
    vecs[2] = '{1'b0, 1'b0, NOP,  NOP,  2'd2, 2, I(3), I(4), 2};
    vecs[3] = '{1'b0, 1'b0, NOP,  NOP,  2'd2, 0, NOP,  NOP,  4};
    vecs[4] = '{1'b1, 1'b1, NOP,  I(5), 2'd0, 1, I(5), NOP,  4};
    vecs[5] = '{1'b1, 1'b0, NOP,  NOP,  2'd0, 1, I(5), NOP,  4};
    vecs[6] = '{1'b0, 1'b0, NOP,  NOP,  2'd3, 0, NOP,  NOP,  5};
    vecs[7] = '{1'b1, 1'b0, I(6), NOP,  2'd1, 1, I(6), NOP,  5};
    vecs[8] = '{1'b1, 1'b1, I(8), I(7), 2'd1, 2, I(7), I(8), 6};
    vecs[9] = '{1'b0, 1'b0, NOP,  NOP,  2'd2, 0, NOP,  NOP,  8};

    do_reset();
    chk("reset out0_inst", out0_inst, NOP);

    for (int n = 0; n < 10; n++) begin
      step(vecs[n].v, vecs[n].f, vecs[n].i0, vecs[n].i1, vecs[n].take, $sformatf("vec%0d", n));
      chk($sformatf("vec%0d tbl_count", n), 32'(debug_count), 32'(vecs[n].exp_cnt));
      chk($sformatf("vec%0d tbl_out0", n), out0_inst, vecs[n].exp_o0);
      chk($sformatf("vec%0d tbl_out1", n), out1_inst, vecs[n].exp_o1);
      chk($sformatf("vec%0d tbl_data0", n), out0_data, exp_data(vecs[n].exp_o0));
      chk($sformatf("vec%0d tbl_rc", n), retire_count, vecs[n].exp_rc);
    end

    // backpressure: ready at 6, not at 8, refused pair sets overflow and leaves contents alone
    do_reset();
    for (int n = 0; n < 3; n++) step(1'b1, 1'b0, 32'h200 + 32'(2*n), 32'h201 + 32'(2*n), 2'd0, "fill");
    chk("bp ready_at_6", 32'(in_ready), 32'd1);
    step(1'b1, 1'b0, 32'h206, 32'h207, 2'd0, "fill8");
    chk("bp ready_at_8", 32'(in_ready), 32'd0);
    step(1'b1, 1'b0, 32'h2AA, 32'h2BB, 2'd0, "refused");
    chk("bp overflow", 32'(overflow), 32'd1);
    chk("bp count", 32'(debug_count), 32'd8);
    chk("bp head", out0_inst, 32'h200);
    step(1'b0, 1'b0, NOP, NOP, 2'd2, "full_take2");
    chk("bp take2_ready", 32'(in_ready), 32'd1);

    // wrap: walk both pointers to 7 with count 0
    do_reset();
    for (int n = 0; n < 7; n++) step(1'b1, 1'b0, 32'h300 + 32'(n), NOP, 2'd1, "walk");
    step(1'b0, 1'b0, NOP, NOP, 2'd1, "walk_drain");
    chk("wrap empty", 32'(debug_count), 32'd0);
    step(1'b1, 1'b0, I(6), I(7), 2'd0, "wrap_w1");
    chk("wrap first0", out0_inst, I(6));
    chk("wrap first1", out1_inst, I(7));
    step(1'b1, 1'b0, I(8), I(9), 2'd2, "wrap_w2");
    chk("wrap second0", out0_inst, I(8));
    chk("wrap second1", out1_inst, I(9));
    chk("wrap count", 32'(debug_count), 32'd2);
    chk("wrap data1", out1_data, I(9) ^ MASK);
    step(1'b0, 1'b0, NOP, NOP, 2'd2, "wrap_drain");

    // reset mid-stream with count 5 and a pair on the inputs
    do_reset();
    for (int n = 0; n < 3; n++) step(1'b1, 1'b1, 32'h400 + 32'(n), 32'h410 + 32'(n), 2'd0, "pre");
    step(1'b0, 1'b0, NOP, NOP, 2'd1, "pre_take");
    chk("mid count5", 32'(debug_count), 32'd5);
    in_valid = 1'b1; first = 1'b0; inst0_in = 32'h4F0; inst1_in = 32'h4F1; out_take = 2'd0;
    #2 reset = 1'b0;
    #1;
    chk("mid out0_valid", 32'(out0_valid), 32'd0);
    chk("mid count", 32'(debug_count), 32'd0);
    chk("mid retire_count", retire_count, 32'd0);
    chk("mid in_ready", 32'(in_ready), 32'd1);
    model_reset();
    @(posedge clk); #1;
    reset = 1'b1; in_valid = 1'b0;
    check_model("mid_after");

    // random traffic against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] r0, r1;
      r0 = ($urandom_range(0, 3) == 0) ? NOP : $urandom;
      r1 = ($urandom_range(0, 3) == 0) ? NOP : $urandom;
      step_d(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), r0, r1, $urandom, $urandom,
             2'($urandom_range(0, 3)), "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
